// File: rtl/amm_burst_writer_pkg.sv
// Shared settings, descriptor type and LFSR helpers for the memory checker
// write and read sides.
package amm_burst_writer_pkg;

    localparam int    AMM_DATA_W    = 128;
    localparam int    AMM_ADDR_W    = 12;
    localparam int    AMM_BURST_W   = 11;
    localparam string ADDR_TYPE     = "BYTE";

    localparam int    BYTE_PER_WORD = AMM_DATA_W / 8;
    localparam int    BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);
    localparam int    WORD_ADDR_W   = AMM_ADDR_W - BYTE_ADDR_W;

    // An all-zero LFSR state never leaves zero, so a zero seed is replaced.
    localparam logic [7:0] LFSR_SEED_FIX = 8'hFF;

    typedef enum logic {
        PTRN_FIX = 1'b0,
        PTRN_RND = 1'b1
    } data_ptrn_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0]   word_address;
        logic [AMM_BURST_W-1:0]   burst_word_count;
        logic [BYTE_PER_WORD-1:0] start_mask;
        logic [BYTE_PER_WORD-1:0] end_mask;
        data_ptrn_t               data_ptrn_type;
        logic [7:0]               data_ptrn;
    } pkt_struct_t;

    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] lfsr8_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? LFSR_SEED_FIX : seed;
    endfunction

endpackage

// File: rtl/amm_burst_writer_if.sv
// Descriptor stream plus Avalon-MM write channel of the burst writer.
interface amm_burst_writer_if;
    import amm_burst_writer_pkg::*;

    pkt_struct_t              pkt;
    logic                     pkt_valid;
    logic                     pkt_ready;

    logic [AMM_ADDR_W-1:0]    address;
    logic                     write;
    logic [AMM_DATA_W-1:0]    writedata;
    logic [BYTE_PER_WORD-1:0] byteenable;
    logic [AMM_BURST_W-1:0]   burstcount;
    logic                     waitrequest;

    modport master (
        input  pkt, pkt_valid, waitrequest,
        output pkt_ready, address, write, writedata, byteenable, burstcount
    );

    modport slave (
        output pkt, pkt_valid, waitrequest,
        input  pkt_ready, address, write, writedata, byteenable, burstcount
    );

endinterface

// File: rtl/amm_burst_writer_data_gen_rnd.sv
// LFSR data generator: one byte per LFSR step, a full word of steps unrolled
// per beat. Also instantiated by the read checker to regenerate the data.
module amm_burst_writer_data_gen_rnd
    import amm_burst_writer_pkg::*;
#(
    parameter int DATA_W = AMM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [7:0]        seed,
    input  logic              advance,
    output logic [DATA_W-1:0] data
);

    localparam int BYTES = DATA_W / 8;

    logic [7:0] state;
    logic [7:0] walk;

    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    always_comb begin
        data = '0;
        walk = state;
        for (int i = 0; i < BYTES; i++) begin
            data[8*i +: 8] = walk;
            walk           = lfsr8_step(walk);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= lfsr8_seed(seed);
        end else if (advance) begin
            state <= walk;
        end
    end

endmodule

// File: rtl/amm_burst_writer.sv
// Avalon-MM write master: turns one descriptor into one masked write burst
// carrying fixed-pattern or LFSR data.
module amm_burst_writer #(
    parameter int    AMM_DATA_W  = amm_burst_writer_pkg::AMM_DATA_W,
    parameter int    AMM_ADDR_W  = amm_burst_writer_pkg::AMM_ADDR_W,
    parameter int    AMM_BURST_W = amm_burst_writer_pkg::AMM_BURST_W,
    parameter string ADDR_TYPE   = amm_burst_writer_pkg::ADDR_TYPE
) (
    input  logic               clk,
    input  logic               rst,
    amm_burst_writer_if.master bus,
    output logic               busy,
    output logic               burst_done,
    output logic [31:0]        beat_cnt
);
    import amm_burst_writer_pkg::*;

    localparam int BPW       = AMM_DATA_W / 8;
    localparam int ADDR_B_W  = $clog2(BPW);
    localparam bit WORD_ADDR = (ADDR_TYPE == "WORD");

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    localparam logic [AMM_BURST_W-1:0] ONE_BEAT  = AMM_BURST_W'(1);
    localparam logic [AMM_BURST_W-1:0] TWO_BEATS = AMM_BURST_W'(2);

    logic [0:0]             state;
    logic [AMM_BURST_W-1:0] beats_left;
    logic [BPW-1:0]         end_mask_q;
    data_ptrn_t             ptrn_type_q;
    logic [7:0]             ptrn_q;

    logic                   pkt_acc;
    logic                   beat_acc;
    logic                   desc_load;
    logic [AMM_ADDR_W-1:0]  start_addr;
    logic [AMM_DATA_W-1:0]  rnd_data;

    assign pkt_acc   = bus.pkt_valid && bus.pkt_ready;
    assign beat_acc  = bus.write && !bus.waitrequest;
    assign desc_load = (state == ST_IDLE) && pkt_acc
                       && (bus.pkt.burst_word_count != '0);

    always_comb begin
        start_addr = AMM_ADDR_W'(bus.pkt.word_address);
        if (!WORD_ADDR) begin
            start_addr = start_addr << ADDR_B_W;
        end
    end

    amm_burst_writer_data_gen_rnd #(
        .DATA_W (AMM_DATA_W)
    ) u_data_gen_rnd (
        .clk     (clk),
        .rst     (rst),
        .load    (desc_load),
        .seed    (bus.pkt.data_ptrn),
        .advance (beat_acc),
        .data    (rnd_data)
    );

    // Data is held in registers (LFSR state, pattern) so it is stable under
    // waitrequest without a separate data register.
    assign bus.writedata = (ptrn_type_q == PTRN_RND) ? rnd_data : {BPW{ptrn_q}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            beats_left     <= '0;
            end_mask_q     <= '0;
            ptrn_type_q    <= PTRN_FIX;
            ptrn_q         <= '0;
            bus.pkt_ready  <= 1'b0;
            bus.write      <= 1'b0;
            bus.address    <= '0;
            bus.byteenable <= '0;
            bus.burstcount <= '0;
            busy           <= 1'b0;
            burst_done     <= 1'b0;
            beat_cnt       <= '0;
        end else begin
            burst_done <= 1'b0;

            if (beat_acc && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    bus.pkt_ready <= 1'b1;
                    if (desc_load) begin
                        state          <= ST_WRITE;
                        bus.pkt_ready  <= 1'b0;
                        bus.write      <= 1'b1;
                        busy           <= 1'b1;
                        bus.address    <= start_addr;
                        bus.burstcount <= bus.pkt.burst_word_count;
                        beats_left     <= bus.pkt.burst_word_count;
                        end_mask_q     <= bus.pkt.end_mask;
                        ptrn_type_q    <= bus.pkt.data_ptrn_type;
                        ptrn_q         <= bus.pkt.data_ptrn;
                        bus.byteenable <= (bus.pkt.burst_word_count == ONE_BEAT)
                                          ? (bus.pkt.start_mask & bus.pkt.end_mask)
                                          : bus.pkt.start_mask;
                    end
                end

                ST_WRITE: begin
                    if (beat_acc) begin
                        if (beats_left == ONE_BEAT) begin
                            state         <= ST_IDLE;
                            bus.write     <= 1'b0;
                            busy          <= 1'b0;
                            burst_done    <= 1'b1;
                            bus.pkt_ready <= 1'b1;
                        end else begin
                            beats_left     <= beats_left - ONE_BEAT;
                            bus.byteenable <= (beats_left == TWO_BEATS) ? end_mask_q : '1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amm_burst_writer.sv
// Directed bench for amm_burst_writer: a scoreboard of expected beats is
// filled when each descriptor is sent and drained by a bus monitor.
module tb_amm_burst_writer;
    import amm_burst_writer_pkg::*;

    typedef struct {
        logic [AMM_ADDR_W-1:0]    addr;
        logic [AMM_BURST_W-1:0]   bc;
        logic [BYTE_PER_WORD-1:0] be;
        logic [AMM_DATA_W-1:0]    data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        burst_done;
    logic [31:0] beat_cnt;

    amm_burst_writer_if bus ();

    amm_burst_writer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .burst_done (burst_done),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    int    n_checks     = 0;
    int    n_fail       = 0;
    int    done_cnt     = 0;
    int    write_cycles = 0;
    beat_t exp_q[$];
    beat_t exp_beat;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] s);
        logic fb;
        fb = ^(s & 8'hB8);
        return {s[6:0], fb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [WORD_ADDR_W-1:0] waddr, input int count,
                              input logic [15:0] sm, input logic [15:0] em,
                              input data_ptrn_t ty, input logic [7:0] ptrn);
        beat_t      b;
        logic [7:0] s;
        s = (ptrn == 8'h00) ? 8'hFF : ptrn;
        for (int k = 0; k < count; k++) begin
            b.addr = AMM_ADDR_W'({waddr, 4'h0});
            b.bc   = AMM_BURST_W'(count);
            if (count == 1)          b.be = sm & em;
            else if (k == 0)         b.be = sm;
            else if (k == count - 1) b.be = em;
            else                     b.be = '1;
            for (int i = 0; i < BYTE_PER_WORD; i++) begin
                if (ty == PTRN_FIX) begin
                    b.data[8*i +: 8] = ptrn;
                end else begin
                    b.data[8*i +: 8] = s;
                    s = model_lfsr(s);
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input logic [WORD_ADDR_W-1:0] waddr, input int count,
                            input logic [15:0] sm, input logic [15:0] em,
                            input data_ptrn_t ty, input logic [7:0] ptrn);
        pkt_struct_t p;
        p.word_address     = waddr;
        p.burst_word_count = AMM_BURST_W'(count);
        p.start_mask       = sm;
        p.end_mask         = em;
        p.data_ptrn_type   = ty;
        p.data_ptrn        = ptrn;
        push_burst(waddr, count, sm, em, ty, ptrn);
        bus.pkt       = p;
        bus.pkt_valid = 1'b1;
        for (int t = 0; t < 20 && !bus.pkt_ready; t++) step();
        check("send_ready", bus.pkt_ready, 1'b1);
        step();
        bus.pkt_valid = 1'b0;
        bus.pkt       = '0;
    endtask

    task automatic wait_done(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int t = 1; t <= 200 && !seen; t++) begin
            step();
            if (burst_done) begin
                seen   = 1'b1;
                cycles = t;
            end
        end
        check("done_seen", seen, 1'b1);
        if (seen) begin
            check("done_idle_wr_rdy_busy", {bus.write, bus.pkt_ready, busy}, 3'b010);
            step();
            check("done_width", burst_done, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.write) write_cycles++;
        if (burst_done) done_cnt++;
        if (!rst && bus.write && !bus.waitrequest) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_beat = exp_q.pop_front();
                check("beat_address",    bus.address,    exp_beat.addr);
                check("beat_burstcount", bus.burstcount, exp_beat.bc);
                check("beat_byteenable", bus.byteenable, exp_beat.be);
                check("beat_writedata",  bus.writedata,  exp_beat.data);
            end
        end
    end

    initial begin
        int          cyc;
        int          done_before;
        int          wr_before;
        logic [AMM_ADDR_W+AMM_BURST_W+BYTE_PER_WORD+AMM_DATA_W:0] snap;

        rst             = 1'b1;
        bus.pkt         = '0;
        bus.pkt_valid   = 1'b0;
        bus.waitrequest = 1'b0;
        repeat (3) step();

        check("rst_pkt_ready",  bus.pkt_ready,  1'b0);
        check("rst_write",      bus.write,      1'b0);
        check("rst_address",    bus.address,    '0);
        check("rst_writedata",  bus.writedata,  '0);
        check("rst_byteenable", bus.byteenable, '0);
        check("rst_burstcount", bus.burstcount, '0);
        check("rst_busy_done",  {busy, burst_done}, 2'b00);
        check("rst_beat_cnt",   beat_cnt,       32'd0);

        rst = 1'b0;
        step();
        step();
        check("idle_pkt_ready", bus.pkt_ready, 1'b1);

        // Fixed pattern, three beats, byte addressing.
        send_pkt(8'h10, 3, 16'hFFF0, 16'h000F, PTRN_FIX, 8'hA5);
        check("fix_busy", busy, 1'b1);
        wait_done(cyc);
        check("fix_latency", cyc, 3);
        check("fix_beat_cnt", beat_cnt, 32'd3);

        // Single beat: both masks applied together.
        send_pkt(8'h02, 1, 16'hFF00, 16'h0FFF, PTRN_FIX, 8'h3C);
        check("single_be", bus.byteenable, 16'h0F00);
        wait_done(cyc);
        check("single_latency", cyc, 1);
        check("single_beat_cnt", beat_cnt, 32'd4);

        // LFSR sequence from seed 0x01.
        send_pkt(8'h05, 1, 16'hFFFF, 16'hFFFF, PTRN_RND, 8'h01);
        check("rnd_seed1_bytes", bus.writedata[39:0], 40'h11_08_04_02_01);
        wait_done(cyc);

        // Zero seed behaves as 0xFF, state carried into the second beat.
        send_pkt(8'h06, 2, 16'hFFFE, 16'h7FFF, PTRN_RND, 8'h00);
        check("rnd_seed0_byte0", bus.writedata[7:0], 8'hFF);
        wait_done(cyc);
        check("rnd_beat_cnt", beat_cnt, 32'd7);

        // Five-cycle stall on the second of four beats.
        send_pkt(8'h20, 4, 16'hFFFC, 16'h3FFF, PTRN_RND, 8'h5A);
        step();
        bus.waitrequest = 1'b1;
        snap = {bus.write, bus.address, bus.burstcount, bus.byteenable, bus.writedata};
        check("stall_be_middle", bus.byteenable, 16'hFFFF);
        for (int t = 0; t < 5; t++) begin
            step();
            check("stall_hold",
                  {bus.write, bus.address, bus.burstcount, bus.byteenable, bus.writedata}, snap);
        end
        bus.waitrequest = 1'b0;
        wait_done(cyc);
        check("stall_beat_cnt", beat_cnt, 32'd11);

        // Zero-length descriptor is swallowed without bus activity.
        done_before = done_cnt;
        wr_before   = write_cycles;
        send_pkt(8'h30, 0, 16'hFFFF, 16'hFFFF, PTRN_FIX, 8'h11);
        repeat (4) step();
        check("zero_no_write", write_cycles - wr_before, 0);
        check("zero_no_done",  done_cnt - done_before, 0);
        check("zero_ready",    bus.pkt_ready, 1'b1);
        send_pkt(8'h31, 2, 16'hFFFF, 16'hFFFF, PTRN_FIX, 8'h22);
        wait_done(cyc);
        check("after_zero_beat_cnt", beat_cnt, 32'd13);

        // Reset while the second of eight beats is on the bus.
        done_before = done_cnt;
        send_pkt(8'h03, 8, 16'hFFFF, 16'hFFFF, PTRN_FIX, 8'h77);
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
        check("midrst_write",     bus.write,     1'b0);
        check("midrst_busy",      busy,          1'b0);
        check("midrst_pkt_ready", bus.pkt_ready, 1'b0);
        check("midrst_beat_cnt",  beat_cnt,      32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("midrst_release_ready", bus.pkt_ready, 1'b1);
        check("midrst_no_done", done_cnt - done_before, 0);

        send_pkt(8'h40, 1, 16'h00FF, 16'hFFFF, PTRN_FIX, 8'hC3);
        wait_done(cyc);
        check("recover_beat_cnt", beat_cnt, 32'd1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amm_burst_writer.md
Name: amm_burst_writer

Overview:
Write-side Avalon-MM master stage of the memory checker. Consumes one pkt_struct_t per burst from the transaction generator and issues the matching Avalon-MM write burst. Applies the start/end byte masks and generates fixed or LFSR-random data. The read checker regenerates the same data, so the data rules below are normative for both sides.

Parameters:
AMM_DATA_W, settings_pkg::AMM_DATA_W (128), Avalon data width
AMM_ADDR_W, settings_pkg::AMM_ADDR_W (12), Avalon address width
AMM_BURST_W, settings_pkg::AMM_BURST_W (11), burstcount width
ADDR_TYPE, settings_pkg::ADDR_TYPE ("BYTE"), "BYTE" or "WORD" addressing of the slave

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
pkt_i  in  $bits(pkt_struct_t)  burst descriptor
pkt_valid_i  in  1  descriptor valid
pkt_ready_o  out  1  descriptor accepted on valid&&ready
amm_address_o  out  AMM_ADDR_W  burst start address
amm_write_o  out  1  write request
amm_writedata_o  out  AMM_DATA_W  beat data
amm_byteenable_o  out  BYTE_PER_WORD  beat byte enables
amm_burstcount_o  out  AMM_BURST_W  beats in burst
amm_waitrequest_i  in  1  slave stall
busy_o  out  1  burst in progress
burst_done_o  out  1  one-cycle pulse after the last beat is accepted
beat_cnt_o  out  32  total accepted beats since reset, saturating at 2^32-1

Behaviour:
- Reset values: pkt_ready_o=0, amm_write_o=0, address/data/byteenable/burstcount=0, busy_o=0, burst_done_o=0, beat_cnt_o=0. FSM=IDLE.
- FSM IDLE: pkt_ready_o=1 (registered).
  - On accept with burst_word_count!=0: latch pkt; go to WRITE next cycle.
  - On accept with burst_word_count==0: descriptor discarded; stay IDLE; no bus activity, no done pulse.
- WRITE: amm_write_o=1; busy_o=1; pkt_ready_o=0.
  - address and burstcount are constant for the whole burst.
  - address = word_address<<ADDR_B_W for "BYTE", word_address zero-extended for "WORD".
  - burstcount = burst_word_count.
- Beat accepted when amm_write_o && !amm_waitrequest_i. On accept: beat counter++, beat_cnt_o++, next data/byteenable presented the following cycle. While waitrequest=1, all outputs hold.
- Byteenable per beat:
  - single-beat burst: start_mask&end_mask
  - first beat: start_mask
  - last beat: end_mask
  - middle beats: all ones
- Last beat accepted -> next cycle: FSM=IDLE, amm_write_o=0, burst_done_o=1 for 1 cycle. The earliest next accept is that same IDLE cycle, so there is one idle bus cycle between bursts.
- Data, byte i at writedata[8i+7:8i]:
  - FIX (data_ptrn_type=0): every byte = data_ptrn.
  - RND (data_ptrn_type=1): 8-bit LFSR, seed = data_ptrn (0 replaced by 8'hFF).
    - step: s <= {s[6:0], s[7]^s[5]^s[4]^s[3]}.
    - byte k of the burst (k = beat*BYTE_PER_WORD + i) equals the state after k steps.
    - State is carried across beats; BYTE_PER_WORD steps are unrolled combinationally per beat.
    - Masked bytes still consume steps.
- Reset mid-burst: FSM to IDLE on the next edge, amm_write_o drops; the slave burst is abandoned (accepted limitation); no done pulse.
- beat_cnt_o does not wrap.

Decomposition:
- settings_pkg: add BYTE_PER_WORD = AMM_DATA_W/8 and BYTE_ADDR_W = $clog2(BYTE_PER_WORD); pkt_struct_t depends on these.
- settings_pkg: add the LFSR seed-fix constant and a function lfsr8_step() shared with the read checker.
- Sub-module data_gen_rnd: seed load, per-beat advance, AMM_DATA_W output; reused by the checker.

Test Plan:
- FIX burst, defaults: word_address=0x10, count=3, start=0xFFF0, end=0x000F, ptrn=0xA5 -> address 0x100, burstcount 3, byteenable 0xFFF0/0xFFFF/0x000F, all bytes 0xA5, done pulse, beat_cnt_o=3.
- Single beat: count=1, start=0xFF00, end=0x0FFF -> one beat, byteenable 0x0F00, done one cycle later.
- RND seed 0x01, count=1 -> bytes 0..4 = 0x01,0x02,0x04,0x08,0x11; seed 0x00 behaves as seed 0xFF.
- Waitrequest held high 5 cycles on beat 2 of 4 -> outputs stable throughout, exactly 4 beats accepted, LFSR not advanced during the stall.
- count=0 descriptor, then a valid descriptor -> first produces no write and no done pulse; second runs normally.
- Reset asserted mid-burst (beat 2 of 8) -> next cycle amm_write_o=0, busy_o=0, pkt_ready_o=0 during reset, 1 after release.
